// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// Used by the arbiter top and its per-master request slots.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitResp
  } arb_state_e;

  typedef enum logic {
    MstIfu,
    MstLsu
  } mst_e;

  localparam logic [1:0] SizeB = 2'd0;
  localparam logic [1:0] SizeH = 2'd1;
  localparam logic [1:0] SizeW = 2'd2;

  localparam logic [31:0] ErrDataDefault = 32'hDEADBEEF;

endpackage

// File: rtl/mem_req_slot.sv
// One master's pending-request latch plus its captured request fields.
// A pulse is ignored while a request is already pending or the master owns the bus.
module mem_req_slot
  import mem_arb_pkg::*;
#(
  parameter int unsigned AddrW = 32,
  parameter int unsigned DataW = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  input  logic               busy_i,
  input  logic               clr_i,
  input  logic [AddrW-1:0]   addr_i,
  input  logic [1:0]         size_i,
  input  logic               wen_i,
  input  logic [DataW-1:0]   wdata_i,
  input  logic [DataW/8-1:0] wmask_i,
  output logic               pend_o,
  output logic [AddrW-1:0]   addr_o,
  output logic [1:0]         size_o,
  output logic               wen_o,
  output logic [DataW-1:0]   wdata_o,
  output logic [DataW/8-1:0] wmask_o
);

  logic               pend_q, pend_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic [1:0]         size_q, size_d;
  logic               wen_q, wen_d;
  logic [DataW-1:0]   wdata_q, wdata_d;
  logic [DataW/8-1:0] wmask_q, wmask_d;
  logic               capture;

  assign capture = req_i && !pend_q && !busy_i;

  always_comb begin
    pend_d  = pend_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    // clr_i needs pend_q set and capture needs it clear, so they never coincide
    if (clr_i) begin
      pend_d = 1'b0;
    end
    if (capture) begin
      pend_d  = 1'b1;
      addr_d  = addr_i;
      size_d  = size_i;
      wen_d   = wen_i;
      wdata_d = wdata_i;
      wmask_d = wmask_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q  <= 1'b0;
      addr_q  <= '0;
      size_q  <= SizeB;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign pend_o  = pend_q;
  assign addr_o  = addr_q;
  assign size_o  = size_q;
  assign wen_o   = wen_q;
  assign wdata_o = wdata_q;
  assign wmask_o = wmask_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter merging fetch and load/store ports onto one memory port,
// one transaction outstanding, with a response watchdog.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ErrDataDefault)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_reqValid,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_respValid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_reqValid,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [1:0]          lsu_size,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_respValid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_reqValid,
  input  logic                mem_reqReady,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [1:0]          mem_size,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_respValid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err_timeout
);

  localparam int unsigned MaskW  = DATA_W / 8;
  localparam int unsigned TimerW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e        state_q, state_d;
  mst_e              owner_q, owner_d, last_q, last_d;
  logic [TimerW-1:0] timer_q, timer_d;

  logic              mreq_q, mreq_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [1:0]        msize_q, msize_d;
  logic              mwen_q, mwen_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;
  logic [MaskW-1:0]  mwmask_q, mwmask_d;

  logic              ifu_resp_q, ifu_resp_d, lsu_resp_q, lsu_resp_d;
  logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
  logic              err_q, err_d;

  logic              ifu_pend, lsu_pend, ifu_busy, lsu_busy, grant_ifu, grant_lsu;
  logic [ADDR_W-1:0] ifu_s_addr, lsu_s_addr;
  logic [1:0]        ifu_s_size, lsu_s_size;
  logic              ifu_s_wen, lsu_s_wen;
  logic [DATA_W-1:0] ifu_s_wdata, lsu_s_wdata;
  logic [MaskW-1:0]  ifu_s_wmask, lsu_s_wmask;
  logic              resp_fire;
  logic [DATA_W-1:0] resp_data;

  assign ifu_busy = (state_q != StIdle) && (owner_q == MstIfu);
  assign lsu_busy = (state_q != StIdle) && (owner_q == MstLsu);

  // Ties go to whichever master was not granted last
  assign grant_lsu = (state_q == StIdle) && lsu_pend && (!ifu_pend || last_q == MstIfu);
  assign grant_ifu = (state_q == StIdle) && ifu_pend && !grant_lsu;

  mem_req_slot #(
    .AddrW (ADDR_W),
    .DataW (DATA_W)
  ) u_ifu_slot (
    .clk_i   (clock),
    .rst_ni  (reset),
    .req_i   (ifu_reqValid),
    .busy_i  (ifu_busy),
    .clr_i   (grant_ifu),
    .addr_i  (ifu_addr),
    .size_i  (SizeW),
    .wen_i   (1'b0),
    .wdata_i ('0),
    .wmask_i ('0),
    .pend_o  (ifu_pend),
    .addr_o  (ifu_s_addr),
    .size_o  (ifu_s_size),
    .wen_o   (ifu_s_wen),
    .wdata_o (ifu_s_wdata),
    .wmask_o (ifu_s_wmask)
  );

  mem_req_slot #(
    .AddrW (ADDR_W),
    .DataW (DATA_W)
  ) u_lsu_slot (
    .clk_i   (clock),
    .rst_ni  (reset),
    .req_i   (lsu_reqValid),
    .busy_i  (lsu_busy),
    .clr_i   (grant_lsu),
    .addr_i  (lsu_addr),
    .size_i  (lsu_size),
    .wen_i   (lsu_wen),
    .wdata_i (lsu_wdata),
    .wmask_i (lsu_wmask),
    .pend_o  (lsu_pend),
    .addr_o  (lsu_s_addr),
    .size_o  (lsu_s_size),
    .wen_o   (lsu_s_wen),
    .wdata_o (lsu_s_wdata),
    .wmask_o (lsu_s_wmask)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    timer_d     = timer_q;
    mreq_d      = mreq_q;
    maddr_d     = maddr_q;
    msize_d     = msize_q;
    mwen_d      = mwen_q;
    mwdata_d    = mwdata_q;
    mwmask_d    = mwmask_q;
    ifu_resp_d  = 1'b0;
    lsu_resp_d  = 1'b0;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    err_d       = err_q;
    resp_fire   = 1'b0;
    resp_data   = mem_rdata;

    unique case (state_q)
      StIdle: begin
        if (grant_lsu) begin
          owner_d  = MstLsu;
          last_d   = MstLsu;
          mreq_d   = 1'b1;
          maddr_d  = lsu_s_addr;
          msize_d  = lsu_s_size;
          mwen_d   = lsu_s_wen;
          mwdata_d = lsu_s_wdata;
          mwmask_d = lsu_s_wmask;
          state_d  = StIssue;
        end else if (grant_ifu) begin
          owner_d  = MstIfu;
          last_d   = MstIfu;
          mreq_d   = 1'b1;
          maddr_d  = ifu_s_addr;
          msize_d  = ifu_s_size;
          mwen_d   = ifu_s_wen;
          mwdata_d = ifu_s_wdata;
          mwmask_d = ifu_s_wmask;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (mem_reqReady) begin
          mreq_d  = 1'b0;
          timer_d = '0;
          state_d = StWaitResp;
        end
      end
      StWaitResp: begin
        if (mem_respValid) begin
          resp_fire = 1'b1;
          state_d   = StIdle;
        end else if (TIMEOUT != 0 && timer_q == TimerW'(TIMEOUT)) begin
          resp_fire = 1'b1;
          resp_data = ERR_DATA;
          err_d     = 1'b1;
          state_d   = StIdle;
        end else if (timer_q != TimerW'(TIMEOUT)) begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (resp_fire) begin
      if (owner_q == MstIfu) begin
        ifu_resp_d  = 1'b1;
        ifu_rdata_d = resp_data;
      end else begin
        lsu_resp_d  = 1'b1;
        lsu_rdata_d = resp_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      owner_q     <= MstIfu;
      last_q      <= MstIfu;
      timer_q     <= '0;
      mreq_q      <= 1'b0;
      maddr_q     <= '0;
      msize_q     <= SizeB;
      mwen_q      <= 1'b0;
      mwdata_q    <= '0;
      mwmask_q    <= '0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      timer_q     <= timer_d;
      mreq_q      <= mreq_d;
      maddr_q     <= maddr_d;
      msize_q     <= msize_d;
      mwen_q      <= mwen_d;
      mwdata_q    <= mwdata_d;
      mwmask_q    <= mwmask_d;
      ifu_resp_q  <= ifu_resp_d;
      lsu_resp_q  <= lsu_resp_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_reqValid  = mreq_q;
  assign mem_addr      = maddr_q;
  assign mem_size      = msize_q;
  assign mem_wen       = mwen_q;
  assign mem_wdata     = mwdata_q;
  assign mem_wmask     = mwmask_q;
  assign ifu_respValid = ifu_resp_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_respValid = lsu_resp_q;
  assign lsu_rdata     = lsu_rdata_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: fetch, store, ties, backpressure,
// watchdog expiry and asynchronous reset in flight.
module tb_mem_arbiter;

  localparam int unsigned Timeout = 4;

  logic        clock;
  logic        reset;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic [1:0]  lsu_size;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        mem_reqValid;
  logic        mem_reqReady;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;
  logic        err_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;

  mem_arbiter #(
    .TIMEOUT (Timeout)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ifu_reqValid  (ifu_reqValid),
    .ifu_addr      (ifu_addr),
    .ifu_respValid (ifu_respValid),
    .ifu_rdata     (ifu_rdata),
    .lsu_reqValid  (lsu_reqValid),
    .lsu_addr      (lsu_addr),
    .lsu_size      (lsu_size),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_respValid (lsu_respValid),
    .lsu_rdata     (lsu_rdata),
    .mem_reqValid  (mem_reqValid),
    .mem_reqReady  (mem_reqReady),
    .mem_addr      (mem_addr),
    .mem_size      (mem_size),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_respValid (mem_respValid),
    .mem_rdata     (mem_rdata),
    .err_timeout   (err_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_reqValid && mem_reqReady) hs_cnt <= hs_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_ifu(input logic [31:0] addr);
    ifu_reqValid = 1'b1;
    ifu_addr     = addr;
    tick();
    ifu_reqValid = 1'b0;
  endtask

  task automatic set_lsu(input logic [31:0] addr, input logic [1:0] size, input logic wen,
                         input logic [31:0] wdata, input logic [3:0] wmask);
    lsu_reqValid = 1'b1;
    lsu_addr     = addr;
    lsu_size     = size;
    lsu_wen      = wen;
    lsu_wdata    = wdata;
    lsu_wmask    = wmask;
  endtask

  // Bounded wait for a request, then compare every request field
  task automatic wait_req(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic wen, input logic [31:0] wdata, input logic [3:0] wmask);
    int i;
    i = 0;
    while (!mem_reqValid && i < 20) begin
      tick();
      i++;
    end
    check_eq({tag, "_req_seen"}, mem_reqValid, 1'b1);
    check_eq({tag, "_fields"}, {mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask},
             {addr, size, wen, wdata, wmask});
  endtask

  // Handshake on the next edge, memory answers the cycle after
  task automatic serve(input string tag, input logic [31:0] rd);
    mem_reqReady = 1'b1;
    tick();
    check_eq({tag, "_req_drop"}, mem_reqValid, 1'b0);
    mem_respValid = 1'b1;
    mem_rdata     = rd;
    tick();
    mem_respValid = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic is_lsu, input logic [31:0] rd);
    check_eq({tag, "_resp_vld"}, {ifu_respValid, lsu_respValid}, is_lsu ? 2'b01 : 2'b10);
    check_eq({tag, "_rdata"}, is_lsu ? lsu_rdata : ifu_rdata, rd);
    tick();
    check_eq({tag, "_resp_end"}, {ifu_respValid, lsu_respValid}, 2'b00);
    check_eq({tag, "_rdata_hold"}, is_lsu ? lsu_rdata : ifu_rdata, rd);
  endtask

  initial begin
    int hs0;
    int n;
    reset         = 1'b1;
    ifu_reqValid  = 1'b0;
    ifu_addr      = '0;
    lsu_reqValid  = 1'b0;
    lsu_addr      = '0;
    lsu_size      = '0;
    lsu_wen       = 1'b0;
    lsu_wdata     = '0;
    lsu_wmask     = '0;
    mem_reqReady  = 1'b1;
    mem_respValid = 1'b0;
    mem_rdata     = '0;
    #3 reset = 1'b0;
    tick();
    tick();
    check_eq("reset_outputs", {ifu_respValid, ifu_rdata, lsu_respValid, lsu_rdata, mem_reqValid,
             mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask, err_timeout}, '0);
    reset = 1'b1;
    tick();

    // Fetch only: request at t+2, response at t+4
    pulse_ifu(32'h8000_0000);
    check_eq("fetch_t1_idle", mem_reqValid, 1'b0);
    tick();
    check_eq("fetch_t2_req", mem_reqValid, 1'b1);
    wait_req("fetch", 32'h8000_0000, 2'd2, 1'b0, 32'h0, 4'h0);
    serve("fetch", 32'h0000_0013);
    check_resp("fetch", 1'b0, 32'h0000_0013);

    // Tie with last grant IFU: LSU first
    ifu_reqValid = 1'b1;
    ifu_addr     = 32'h8000_0040;
    set_lsu(32'h2000_0000, 2'd2, 1'b0, 32'h0, 4'hF);
    tick();
    ifu_reqValid = 1'b0;
    lsu_reqValid = 1'b0;
    wait_req("tie1_lsu", 32'h2000_0000, 2'd2, 1'b0, 32'h0, 4'hF);
    serve("tie1_lsu", 32'h1111_2222);
    check_resp("tie1_lsu", 1'b1, 32'h1111_2222);
    wait_req("tie1_ifu", 32'h8000_0040, 2'd2, 1'b0, 32'h0, 4'h0);
    serve("tie1_ifu", 32'h3333_4444);
    check_resp("tie1_ifu", 1'b0, 32'h3333_4444);

    // Store
    set_lsu(32'h1000_0004, 2'd1, 1'b1, 32'hCAFE_BABE, 4'b1100);
    tick();
    lsu_reqValid = 1'b0;
    wait_req("store", 32'h1000_0004, 2'd1, 1'b1, 32'hCAFE_BABE, 4'b1100);
    serve("store", 32'h0);
    check_resp("store", 1'b1, 32'h0);

    // Tie with last grant LSU: IFU first
    ifu_reqValid = 1'b1;
    ifu_addr     = 32'h8000_0080;
    set_lsu(32'h2000_0010, 2'd0, 1'b1, 32'h0000_00AB, 4'b0001);
    tick();
    ifu_reqValid = 1'b0;
    lsu_reqValid = 1'b0;
    wait_req("tie2_ifu", 32'h8000_0080, 2'd2, 1'b0, 32'h0, 4'h0);
    serve("tie2_ifu", 32'h5555_6666);
    check_resp("tie2_ifu", 1'b0, 32'h5555_6666);
    wait_req("tie2_lsu", 32'h2000_0010, 2'd0, 1'b1, 32'h0000_00AB, 4'b0001);
    serve("tie2_lsu", 32'h7777_8888);
    check_resp("tie2_lsu", 1'b1, 32'h7777_8888);

    // Backpressure: 7 stalled cycles, handshake on the 8th
    mem_reqReady = 1'b0;
    hs0 = hs_cnt;
    pulse_ifu(32'h8000_00C0);
    wait_req("bp", 32'h8000_00C0, 2'd2, 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq("bp_stall", {mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask},
               {1'b1, 32'h8000_00C0, 2'd2, 1'b0, 32'h0, 4'h0});
    end
    serve("bp", 32'h9999_0000);
    check_resp("bp", 1'b0, 32'h9999_0000);
    tick();
    tick();
    check_eq("bp_one_txn", hs_cnt - hs0, 1);
    check_eq("bp_no_reissue", mem_reqValid, 1'b0);

    // Watchdog expiry
    pulse_ifu(32'h8000_0100);
    wait_req("to", 32'h8000_0100, 2'd2, 1'b0, 32'h0, 4'h0);
    tick();
    check_eq("to_err_before", err_timeout, 1'b0);
    n = 0;
    while (!ifu_respValid && n < 20) begin
      tick();
      n++;
    end
    check_eq("to_resp_seen", ifu_respValid, 1'b1);
    check_eq("to_latency_ok", (n >= Timeout) && (n <= Timeout + 2), 1'b1);
    check_eq("to_rdata", ifu_rdata, 32'hDEAD_BEEF);
    check_eq("to_err_set", err_timeout, 1'b1);
    check_eq("to_lsu_quiet", lsu_respValid, 1'b0);
    tick();
    set_lsu(32'h2000_0020, 2'd2, 1'b0, 32'h0, 4'hF);
    tick();
    lsu_reqValid = 1'b0;
    wait_req("post_to", 32'h2000_0020, 2'd2, 1'b0, 32'h0, 4'hF);
    serve("post_to", 32'h0BAD_F00D);
    check_resp("post_to", 1'b1, 32'h0BAD_F00D);
    check_eq("to_err_sticky", err_timeout, 1'b1);

    // Reset while waiting for a response
    pulse_ifu(32'h8000_0200);
    wait_req("rst", 32'h8000_0200, 2'd2, 1'b0, 32'h0, 4'h0);
    tick();
    #2 reset = 1'b0;
    #1;
    check_eq("rst_async_outputs", {ifu_respValid, ifu_rdata, lsu_respValid, lsu_rdata,
             mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask, err_timeout}, '0);
    tick();
    reset         = 1'b1;
    mem_respValid = 1'b1;
    mem_rdata     = 32'hFFFF_FFFF;
    tick();
    mem_respValid = 1'b0;
    check_eq("rst_stray_ignored", {ifu_respValid, lsu_respValid, mem_reqValid}, 3'b000);
    tick();
    check_eq("rst_stray_quiet", {ifu_respValid, lsu_respValid, ifu_rdata}, 34'h0);
    pulse_ifu(32'h8000_0300);
    wait_req("post_rst", 32'h8000_0300, 2'd2, 1'b0, 32'h0, 4'h0);
    serve("post_rst", 32'h0000_0093);
    check_resp("post_rst", 1'b0, 32'h0000_0093);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
